// File: rtl/imm_extend_stage_pkg.sv
// Shared select codes, skid-stage state encoding and instruction width for the ID-stage immediate extender.
package imm_extend_stage_pkg;

  localparam int INSTR_W = 32;

  localparam logic [2:0] IMM_SEL_U     = 3'b000;
  localparam logic [2:0] IMM_SEL_I     = 3'b001;
  localparam logic [2:0] IMM_SEL_SHAMT = 3'b010;
  localparam logic [2:0] IMM_SEL_S     = 3'b011;
  localparam logic [2:0] IMM_SEL_B     = 3'b100;
  localparam logic [2:0] IMM_SEL_J     = 3'b101;
  localparam logic [2:0] IMM_SEL_ZIMM  = 3'b110;
  localparam logic [2:0] IMM_SEL_RSVD  = 3'b111;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

endpackage

// File: rtl/imm_extend_lane.sv
// Per-lane immediate extraction and XLEN extension; purely combinational (0 cycles).
// No backpressure of its own: it follows whatever instruction/select the stage presents.
module imm_extend_lane
  import imm_extend_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic [2:0]         sel,
  output logic [XLEN-1:0]    imm,
  output logic               err
);

  // Only RV64 shift amounts carry a sixth bit; bit 30 (arith/logical) is never part of shamt.
  logic shamt_msb;
  logic unused_opcode;

  assign shamt_msb     = (XLEN == 64) ? instr[25] : 1'b0;
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    imm = '0;
    err = 1'b0;
    case (sel)
      IMM_SEL_U:     imm = XLEN'($signed({instr[31:12], 12'b0}));
      IMM_SEL_I:     imm = XLEN'($signed(instr[31:20]));
      IMM_SEL_SHAMT: imm = XLEN'({shamt_msb, instr[24:20]});
      IMM_SEL_S:     imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      IMM_SEL_B:     imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      IMM_SEL_J:     imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      IMM_SEL_ZIMM:  imm = XLEN'(instr[19:15]);
      default:       err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extend_stage.sv
// Registered LANES-wide immediate extender; 1 cycle from accept to out_valid.
// Backpressure: 2-entry skid (output + skid register); in_ready depends on state only, flush empties both.
module imm_extend_stage
  import imm_extend_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int LANES = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*INSTR_W-1:0] in_instr,
  input  logic [LANES*3-1:0]       in_sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*XLEN-1:0]    out_imm,
  output logic [LANES-1:0]         out_err
);

  stage_state_e state_q, state_d;

  logic [LANES*XLEN-1:0] ext_imm;
  logic [LANES-1:0]      ext_err;
  logic [LANES*XLEN-1:0] out_imm_q, skid_imm_q;
  logic [LANES-1:0]      out_err_q, skid_err_q;

  logic accept, emit;
  logic load_out_from_in, load_out_from_skid, load_skid;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    imm_extend_lane #(
      .XLEN (XLEN)
    ) u_lane (
      .instr (in_instr[INSTR_W*k +: INSTR_W]),
      .sel   (in_sel[3*k +: 3]),
      .imm   (ext_imm[XLEN*k +: XLEN]),
      .err   (ext_err[k])
    );
  end

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    load_out_from_in   = 1'b0;
    load_out_from_skid = 1'b0;
    load_skid          = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d          = ONE;
            load_out_from_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && !emit) begin
            state_d   = TWO;
            load_skid = 1'b1;
          end else if (emit && !accept) begin
            state_d = EMPTY;
          end else if (accept && emit) begin
            load_out_from_in = 1'b1;
          end
        end
        TWO: begin
          // Upstream is stalled here, so the skid entry is the only candidate for the output slot.
          if (emit) begin
            state_d            = ONE;
            load_out_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_imm_q  <= '0;
      out_err_q  <= '0;
      skid_imm_q <= '0;
      skid_err_q <= '0;
    end else begin
      if (load_out_from_in) begin
        out_imm_q <= ext_imm;
        out_err_q <= ext_err;
      end else if (load_out_from_skid) begin
        out_imm_q <= skid_imm_q;
        out_err_q <= skid_err_q;
      end
      if (load_skid) begin
        skid_imm_q <= ext_imm;
        skid_err_q <= ext_err;
      end
    end
  end

  assign out_imm = out_imm_q;
  assign out_err = out_err_q;

endmodule

// File: doc/imm_extend_stage.md
Name: imm_extend_stage

Overview:
- Registered, parametrised successor to the combinational immediate extender, sitting in the ID stage between instruction decode and the ID/EX pipeline register.
- Extracts and extends immediates for LANES instructions in parallel to XLEN bits.
- Adds shamt and CSR-zimm modes and an illegal-select flag.
- Decouples the stage with a valid/ready handshake and a 2-entry skid buffer, supporting stall, backpressure and flush.

Parameters:
- XLEN, 32, output immediate width; legal values are 32 and 64.
- LANES, 1, instructions processed per transfer; range 1..4.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous flush from branch/jump resolution.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept a beat.
- in_instr  input  LANES*32  raw instructions; lane k occupies [32k+31:32k].
- in_sel  input  LANES*3  immediate select per lane; lane k occupies [3k+2:3k].
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_imm  output  LANES*XLEN  extended immediates; lane k occupies [XLEN*k+XLEN-1:XLEN*k].
- out_err  output  LANES  per-lane flag indicating the select was reserved (111).

Behaviour:
- Select encoding per lane (i = instr, shown for XLEN=32; sign fill extends to XLEN):
  - 000 U: {i[31:12], 12'b0}, sign-extended to XLEN.
  - 001 I: sext(i[31:20]).
  - 010 shift: zero-extended shamt; i[24:20] when XLEN=32, i[25:20] when XLEN=64. Bit i[30] is never included.
  - 011 S: sext({i[31:25], i[11:7]}).
  - 100 B: sext({i[31], i[7], i[30:25], i[11:8], 1'b0}).
  - 101 J: sext({i[31], i[19:12], i[20], i[30:21], 1'b0}).
  - 110 CSR zimm: zero-extended i[19:15].
  - 111 reserved: imm = 0 and out_err[k] = 1. For every other select, out_err[k] = 0.
- Extension is combinational per lane; the result is captured into the output register.
- Latency is 1 cycle from an accepted beat (in_valid & in_ready) to out_valid.
- Transfers:
  - Accept = in_valid & in_ready.
  - Emit = out_valid & out_ready.
  - Beats are never dropped, duplicated or reordered; all lanes of a beat move together.
- State machine: EMPTY, ONE (output register full), TWO (output register and skid register full).
  - EMPTY: accept → ONE.
  - ONE: accept & !emit → TWO (new beat goes to the skid register); emit & !accept → EMPTY; accept & emit → ONE (new beat goes to the output register); otherwise hold.
  - TWO: emit → ONE (skid moves to the output register); otherwise hold. No accept is possible in TWO.
- in_ready = (state != TWO). It is a registered function of state only, with no combinational path from out_ready.
- out_valid = (state != EMPTY).
- out_imm and out_err are driven from the output register and stay stable while out_valid & !out_ready.
- Flush:
  - Next state is EMPTY and both registers' valid flags are cleared, regardless of in_valid or out_ready in the same cycle.
  - A beat presented in the flush cycle is discarded.
  - out_valid = 0 in the following cycle.
  - Data registers need not clear.
- Reset (asynchronous, any time, including mid-transfer): state = EMPTY, out_valid = 0, in_ready = 1, out_imm = 0, out_err = 0.
- After reset deassertion, in_ready = 1 in the first cycle.

Decomposition:
- Shared package:
  - IMM_SEL_U/I/SHAMT/S/B/J/ZIMM/RSVD as 3-bit localparams.
  - Stage state encoding EMPTY/ONE/TWO.
  - INSTR_W = 32.
- One natural sub-module: imm_extend_lane, a purely combinational (instr, sel) → (imm[XLEN-1:0], err) unit, parametrised by XLEN and instantiated LANES times in a generate loop.
- The top level holds the skid FSM and the registers.

Test Plan:
- LANES=1, XLEN=32, out_ready=1:
  - 0xFFF00093 sel 001 → out_imm 0xFFFFFFFF.
  - 0x12345037 sel 000 → 0x12345000.
  - Each appears exactly one cycle after acceptance.
- 0xFE000EE3 sel 100 → 0xFFFFFFFC; 0x4030D093 sel 010 → 0x00000003; 0x4030D093 sel 111 → imm 0, out_err 1.
- out_ready=0, push beats A, B, C back-to-back:
  - in_ready falls after B; C is held upstream.
  - Raise out_ready → A, B, C are emitted in order on consecutive cycles.
  - in_ready returns to 1 the cycle after the first emit.
- State TWO with in_valid=1: assert flush for 1 cycle → next cycle out_valid=0, in_ready=1; the flushed beats never appear.
- Drop reset_n asynchronously mid-cycle while in TWO → out_valid=0, out_imm=0, in_ready=1 immediately, without waiting for a clock edge.
- LANES=2, XLEN=64: lane0 0x80000037 sel 000 → 0xFFFFFFFF80000000; lane1 0x02F0D093 sel 010 → 0x000000000000002F; both are valid in the same beat.
